// File: rtl/sr_dmem_responder.sv
// Data-memory slave for the CPU memory stage: word RAM behind a posted-write
// buffer with youngest-match read forwarding, plus a small MMIO window.
module sr_dmem_responder #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          WB_DEPTH   = 4,
  parameter logic [23:0] MMIO_PAGE  = 24'hFFFFFF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 memAddr,
  input  logic                        memWriteEnable,
  input  logic                        memRead,
  inout  wire  [31:0]                 memData,
  output logic [31:0]                 gpioOut,
  output logic [$clog2(WB_DEPTH):0]   wbCount
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]           ram     [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wb_idx  [WB_DEPTH];
  logic [31:0]           wb_data [WB_DEPTH];
  logic [PW-1:0]         head, tail, ptr;
  logic [31:0]           cycle_cnt, rdata, fwd;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  is_mmio, is_ram, rd, idle, full, enq, drain, hit;
  logic                  unused_lsb;

  assign unused_lsb = ^memAddr[1:0];
  assign idx     = memAddr[ADDR_WIDTH+1:2];
  assign is_mmio = (memAddr[31:8] == MMIO_PAGE);
  assign is_ram  = !is_mmio && (memAddr[31:ADDR_WIDTH+2] == '0);
  assign rd      = memRead && !memWriteEnable;
  assign idle    = !memRead && !memWriteEnable;
  assign full    = (wbCount == CW'(WB_DEPTH));
  assign enq     = memWriteEnable && is_ram;
  // A write into a full buffer retires the head on the same edge, so nothing stalls.
  assign drain   = (idle && wbCount != '0) || (enq && full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      wbCount   <= '0;
      gpioOut   <= '0;
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (drain) head <= head + PW'(1);
      if (enq)   tail <= tail + PW'(1);
      wbCount <= wbCount + CW'(enq) - CW'(drain);
      if (memWriteEnable && is_mmio && memAddr[7:2] == 6'd1)
        gpioOut <= memData;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      wb_idx[tail]  <= idx;
      wb_data[tail] <= memData;
    end
  end

  always_ff @(posedge clk) begin
    if (drain) ram[wb_idx[head]] <= wb_data[head];
  end

  // Walk oldest to youngest so the last match seen is the most recent write.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    ptr = '0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      ptr = head + PW'(i);
      if (CW'(i) < wbCount && wb_idx[ptr] == idx) begin
        hit = 1'b1;
        fwd = wb_data[ptr];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (is_mmio) begin
      case (memAddr[7:2])
        6'd0:    rdata = cycle_cnt;
        6'd1:    rdata = gpioOut;
        6'd2:    rdata = 32'(wbCount);
        default: rdata = '0;
      endcase
    end else if (is_ram) begin
      rdata = hit ? fwd : ram[idx];
    end
  end

  assign memData = rd ? rdata : 'z;

endmodule

// File: tb/tb_sr_dmem_responder.sv
// Directed self-checking bench for sr_dmem_responder (ADDR_WIDTH=8, WB_DEPTH=4).
module tb_sr_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] memAddr = '0;
  logic        memWriteEnable = 1'b0;
  logic        memRead = 1'b0;
  logic [31:0] bus_drv = '0;
  logic        bus_en = 1'b0;
  wire  [31:0] memData;
  logic [31:0] gpioOut;
  logic [2:0]  wbCount;

  int checks = 0;
  int errors = 0;

  assign memData = bus_en ? bus_drv : 'z;

  sr_dmem_responder #(.ADDR_WIDTH(8), .WB_DEPTH(4), .MMIO_PAGE(24'hFFFFFF)) dut (
    .clk(clk), .rst(rst), .memAddr(memAddr), .memWriteEnable(memWriteEnable),
    .memRead(memRead), .memData(memData), .gpioOut(gpioOut), .wbCount(wbCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    memWriteEnable = 1'b0; memRead = 1'b0; bus_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memWriteEnable = 1'b1; memRead = 1'b0; memAddr = a; bus_drv = d; bus_en = 1'b1;
    @(negedge clk);
    memWriteEnable = 1'b0; bus_en = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    memWriteEnable = 1'b0; memRead = 1'b1; memAddr = a; bus_en = 1'b0;
    #1 check(tag, memData, exp);
    @(negedge clk);
    memRead = 1'b0;
  endtask

  // An undriven bus may resolve to z or to 0 depending on the simulator.
  task automatic bus_silent(input string tag);
    logic [31:0] obs;
    #1 obs = (memData === 32'hzzzz_zzzz) ? 32'h0 : memData;
    check(tag, obs, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    memAddr = 32'hFFFF_FF00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_gpio", gpioOut, 32'h0);
    check("rst_wbcount", 32'(wbCount), 32'h0);
    repeat (3) idle();
    memAddr = 32'hFFFF_FF00;
    bus_silent("bus_idle");
    rd_check("cnt_after3", 32'hFFFF_FF00, 32'd3);

    wr(32'h10, 32'h11);
    wr(32'h10, 32'h22);
    rd_check("fwd_youngest", 32'h10, 32'h22);
    check("wb_two", 32'(wbCount), 32'd2);
    idle();
    idle();
    check("wb_drained", 32'(wbCount), 32'd0);
    rd_check("ram_after_drain", 32'h10, 32'h22);

    for (int i = 0; i < 6; i++) begin
      wr(32'(4 * i), 32'(i + 1));
      if (i == 3) check("wb_peak", 32'(wbCount), 32'd4);
    end
    check("wb_hold_full", 32'(wbCount), 32'd4);
    for (int i = 0; i < 6; i++) rd_check($sformatf("burst_rd%0d", i), 32'(4 * i), 32'(i + 1));
    check("wb_reads_no_drain", 32'(wbCount), 32'd4);
    repeat (4) idle();
    check("wb_burst_drained", 32'(wbCount), 32'd0);
    rd_check("ram_idx5", 32'h14, 32'd6);

    wr(32'hFFFF_FF04, 32'hA5);
    check("gpio_write", gpioOut, 32'hA5);
    check("gpio_no_enq", 32'(wbCount), 32'd0);
    rd_check("gpio_read", 32'hFFFF_FF04, 32'hA5);
    wr(32'h0000_1000, 32'hDEAD);
    check("unmapped_no_enq", 32'(wbCount), 32'd0);
    rd_check("unmapped_read", 32'h0000_1000, 32'h0);
    wr(32'hFFFF_FF14, 32'h5555);
    rd_check("mmio_other_read", 32'hFFFF_FF14, 32'h0);
    check("gpio_kept", gpioOut, 32'hA5);

    wr(32'h0, 32'h100);
    wr(32'h4, 32'h200);
    rd_check("mmio_wbcount", 32'hFFFF_FF08, 32'd2);
    wr(32'h8, 32'h300);
    check("wb_three", 32'(wbCount), 32'd3);
    rst = 1'b1;
    #1;
    check("async_rst_wb", 32'(wbCount), 32'd0);
    check("async_rst_gpio", gpioOut, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd_check("cnt_after_rst", 32'hFFFF_FF00, 32'd0);
    rd_check("discard_idx0", 32'h0, 32'd1);
    rd_check("discard_idx1", 32'h4, 32'd2);
    rd_check("discard_idx2", 32'h8, 32'd3);

    memWriteEnable = 1'b1; memRead = 1'b1; memAddr = 32'h0C; bus_drv = 32'h1230; bus_en = 1'b1;
    #1 check("both_strobes_bus", memData, 32'h1230);
    @(negedge clk);
    memWriteEnable = 1'b0; memRead = 1'b0; bus_en = 1'b0;
    check("both_strobes_enq", 32'(wbCount), 32'd1);
    rd_check("both_strobes_data", 32'h0C, 32'h1230);

    force dut.cycle_cnt = 32'hFFFF_FFFE;
    #1 release dut.cycle_cnt;
    rd_check("cnt_pre_wrap", 32'hFFFF_FF00, 32'hFFFF_FFFE);
    rd_check("cnt_max", 32'hFFFF_FF00, 32'hFFFF_FFFF);
    rd_check("cnt_wrapped", 32'hFFFF_FF00, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
